// File: rtl/ppu_control_pipe_if.sv
// Bundle between the IF/ID register, the PPU control pipe and the datapath stage muxes.
// The master side drives the ID-stage instruction and pipeline controls; the slave side is the pipe.
interface ppu_control_pipe_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      instr_in;
  logic             instr_valid;
  logic             stall_in;
  logic             flush_in;
  logic             id_stall;
  logic [17:0]      ex_ctrl;
  logic [17:0]      mem_ctrl;
  logic [17:0]      wb_ctrl;
  logic [4:0]       ex_dest;
  logic [4:0]       mem_dest;
  logic [4:0]       wb_dest;
  logic             ex_valid;
  logic             mem_valid;
  logic             wb_valid;
  logic             ex_unknown;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output instr_in, instr_valid, stall_in, flush_in,
    input  id_stall, ex_ctrl, mem_ctrl, wb_ctrl, ex_dest, mem_dest, wb_dest,
    input  ex_valid, mem_valid, wb_valid, ex_unknown, instr_count
  );

  modport slave (
    input  instr_in, instr_valid, stall_in, flush_in,
    output id_stall, ex_ctrl, mem_ctrl, wb_ctrl, ex_dest, mem_dest, wb_dest,
    output ex_valid, mem_valid, wb_valid, ex_unknown, instr_count
  );
endinterface

// File: rtl/ppu_control_pipe.sv
// PPU control pipeline: decodes the ID-stage instruction into the 18-bit control word and carries it
// through ID/EX, EX/MEM and MEM/WB with load-use bubble insertion, stall/flush and a decode counter.
module ppu_control_pipe #(
  parameter int CNT_W     = 16,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  ppu_control_pipe_if.slave  pipe
);

  typedef struct packed {
    logic [17:0] ctrl;
    logic [4:0]  dest;
    logic        valid;
    logic        unknown;
  } stage_t;

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_J     = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04, OP_BNE   = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08, OP_ADDIU = 6'h09, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20, OP_LH    = 6'h21, OP_LW   = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24, OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28, OP_SH    = 6'h29, OP_SW   = 6'h2B;

  localparam logic [5:0] FN_JR   = 6'h08, FN_MTHI = 6'h11, FN_MTLO = 6'h13;
  localparam logic [5:0] FN_ADD  = 6'h20, FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24, FN_OR   = 6'h25;

  localparam logic [17:0] CW_SO_SEXT   = 18'h08000;
  localparam logic [17:0] CW_SO_ZEXT   = 18'h10000;
  localparam logic [17:0] CW_SO_UPPER  = 18'h18000;
  localparam logic [17:0] CW_ALU_SUB   = 18'h00800;
  localparam logic [17:0] CW_ALU_AND   = 18'h01000;
  localparam logic [17:0] CW_ALU_OR    = 18'h01800;
  localparam logic [17:0] CW_ALU_PASSB = 18'h02000;
  localparam logic [17:0] CW_LOAD      = 18'h00400;
  localparam logic [17:0] CW_RF_EN     = 18'h00200;
  localparam logic [17:0] CW_BR        = 18'h00100;
  localparam logic [17:0] CW_TA        = 18'h00080;
  localparam logic [17:0] CW_SZ_BYTE   = 18'h00040;
  localparam logic [17:0] CW_SZ_HALF   = 18'h00020;
  localparam logic [17:0] CW_MEM_RW    = 18'h00010;
  localparam logic [17:0] CW_MEM_SE    = 18'h00008;
  localparam logic [17:0] CW_EN_HI     = 18'h00004;
  localparam logic [17:0] CW_EN_LO     = 18'h00002;
  localparam logic [17:0] CW_MEM_EN    = 18'h00001;

  localparam logic [17:0] CW_LOAD_BASE  = CW_SO_SEXT | CW_LOAD | CW_RF_EN | CW_MEM_EN;
  localparam logic [17:0] CW_STORE_BASE = CW_SO_SEXT | CW_MEM_RW | CW_MEM_EN;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [17:0] dec_ctrl;
  logic [4:0]  dec_dest;
  logic        dec_unknown;
  logic        uses_rt;
  logic        id_stall;
  logic        load_en;
  stage_t      ex_d, ex_q, mem_q, wb_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  assign opcode = pipe.instr_in[31:26];
  assign rs     = pipe.instr_in[25:21];
  assign rt     = pipe.instr_in[20:16];
  assign rd     = pipe.instr_in[15:11];
  assign funct  = pipe.instr_in[5:0];

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no decode path can infer a latch.
    dec_ctrl    = '0;
    dec_dest    = '0;
    dec_unknown = 1'b0;
    uses_rt     = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        uses_rt = 1'b1;
        if (pipe.instr_in != 32'd0) begin
          case (funct)
            FN_ADD, FN_ADDU: begin dec_ctrl = CW_RF_EN;              dec_dest = rd; end
            FN_SUB, FN_SUBU: begin dec_ctrl = CW_RF_EN | CW_ALU_SUB; dec_dest = rd; end
            FN_AND:          begin dec_ctrl = CW_RF_EN | CW_ALU_AND; dec_dest = rd; end
            FN_OR:           begin dec_ctrl = CW_RF_EN | CW_ALU_OR;  dec_dest = rd; end
            FN_MTHI:         dec_ctrl = CW_EN_HI;
            FN_MTLO:         dec_ctrl = CW_EN_LO;
            FN_JR:           dec_ctrl = CW_TA;
            default:         dec_unknown = 1'b1;
          endcase
        end
      end
      OP_ADDI, OP_ADDIU: begin dec_ctrl = CW_RF_EN | CW_SO_SEXT;                  dec_dest = rt; end
      OP_ANDI:  begin dec_ctrl = CW_RF_EN | CW_SO_ZEXT | CW_ALU_AND;              dec_dest = rt; end
      OP_ORI:   begin dec_ctrl = CW_RF_EN | CW_SO_ZEXT | CW_ALU_OR;               dec_dest = rt; end
      OP_LUI:   begin dec_ctrl = CW_RF_EN | CW_SO_UPPER | CW_ALU_PASSB;           dec_dest = rt; end
      OP_LW:    begin dec_ctrl = CW_LOAD_BASE;                                    dec_dest = rt; end
      OP_LH:    begin dec_ctrl = CW_LOAD_BASE | CW_SZ_HALF | CW_MEM_SE;           dec_dest = rt; end
      OP_LHU:   begin dec_ctrl = CW_LOAD_BASE | CW_SZ_HALF;                       dec_dest = rt; end
      OP_LB:    begin dec_ctrl = CW_LOAD_BASE | CW_SZ_BYTE | CW_MEM_SE;           dec_dest = rt; end
      OP_LBU:   begin dec_ctrl = CW_LOAD_BASE | CW_SZ_BYTE;                       dec_dest = rt; end
      OP_SW:    begin dec_ctrl = CW_STORE_BASE;              uses_rt = 1'b1; end
      OP_SH:    begin dec_ctrl = CW_STORE_BASE | CW_SZ_HALF; uses_rt = 1'b1; end
      OP_SB:    begin dec_ctrl = CW_STORE_BASE | CW_SZ_BYTE; uses_rt = 1'b1; end
      OP_BEQ, OP_BNE:   begin dec_ctrl = CW_BR | CW_ALU_SUB; uses_rt = 1'b1; end
      OP_BLEZ, OP_BGTZ: dec_ctrl = CW_BR | CW_ALU_SUB;
      OP_J:     dec_ctrl = CW_TA;
      OP_JAL:   begin dec_ctrl = CW_TA | CW_RF_EN; dec_dest = 5'd31; end
      default:  dec_unknown = 1'b1;
    endcase
  end

  // A load in EX whose destination feeds this instruction must wait one cycle for its data.
  assign id_stall = HAZARD_EN && pipe.instr_valid && ex_q.valid && ex_q.ctrl[10] &&
                    (ex_q.dest != 5'd0) &&
                    ((ex_q.dest == rs) || (uses_rt && (ex_q.dest == rt)));

  always_comb begin
    ex_d    = '0;
    load_en = 1'b0;
    if (pipe.instr_valid && !pipe.flush_in && !id_stall) begin
      ex_d.ctrl    = dec_ctrl;
      ex_d.dest    = dec_dest;
      ex_d.valid   = 1'b1;
      ex_d.unknown = dec_unknown;
      load_en      = 1'b1;
    end
    cnt_d = load_en ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else if (!pipe.stall_in) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign pipe.id_stall    = id_stall;
  assign pipe.ex_ctrl     = ex_q.ctrl;
  assign pipe.ex_dest     = ex_q.dest;
  assign pipe.ex_valid    = ex_q.valid;
  assign pipe.ex_unknown  = ex_q.unknown;
  assign pipe.mem_ctrl    = mem_q.ctrl;
  assign pipe.mem_dest    = mem_q.dest;
  assign pipe.mem_valid   = mem_q.valid;
  assign pipe.wb_ctrl     = wb_q.ctrl;
  assign pipe.wb_dest     = wb_q.dest;
  assign pipe.wb_valid    = wb_q.valid;
  assign pipe.instr_count = cnt_q;

endmodule

// File: tb/tb_ppu_control_pipe.sv
// Bench for ppu_control_pipe: a hazard-enabled 16-bit-counter instance and a hazard-disabled
// 2-bit-counter instance share one stimulus stream and are compared against a field-level model.
module tb_ppu_control_pipe;

  typedef struct {
    logic [17:0] ctrl;
    logic [4:0]  dest;
    bit          valid;
    bit          unk;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ppu_control_pipe_if #(.CNT_W(16)) if_a ();
  ppu_control_pipe_if #(.CNT_W(2))  if_b ();

  ppu_control_pipe #(.CNT_W(16), .HAZARD_EN(1'b1)) u_dut_a (.clk(clk), .reset(reset), .pipe(if_a.slave));
  ppu_control_pipe #(.CNT_W(2),  .HAZARD_EN(1'b0)) u_dut_b (.clk(clk), .reset(reset), .pipe(if_b.slave));

  int   total  = 0;
  int   passed = 0;
  int   failed = 0;
  ent_t ma[3], mb[3];
  int unsigned cnt_a, cnt_b;
  logic [31:0] cur_ins;
  bit   cur_v, cur_st, cur_fl;
  bit   last_stall_a;
  logic obs_stall_a, obs_stall_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Decode straight from the field table: fill each field by name, then pack.
  function automatic ent_t ref_decode(input logic [31:0] w);
    ent_t e;
    logic [5:0] op = w[31:26];
    logic [5:0] fn = w[5:0];
    logic [2:0] so = 3'd0;
    logic [3:0] alu = 4'd0;
    logic [1:0] size = 2'd0;
    bit ld = 0, rf = 0, br = 0, ta = 0, rw = 0, se = 0, hi = 0, lo = 0, men = 0, unk = 0;
    logic [4:0] dest = 5'd0;
    if (w == 32'd0) begin
    end else if (op == 6'h00) begin
      case (fn)
        6'h20, 6'h21: rf = 1;
        6'h22, 6'h23: begin rf = 1; alu = 4'd1; end
        6'h24:        begin rf = 1; alu = 4'd2; end
        6'h25:        begin rf = 1; alu = 4'd3; end
        6'h11:        hi = 1;
        6'h13:        lo = 1;
        6'h08:        ta = 1;
        default:      unk = 1;
      endcase
      if (rf) dest = w[15:11];
    end else begin
      case (op)
        6'h08, 6'h09: begin rf = 1; so = 3'd1; end
        6'h0C:        begin rf = 1; so = 3'd2; alu = 4'd2; end
        6'h0D:        begin rf = 1; so = 3'd2; alu = 4'd3; end
        6'h0F:        begin rf = 1; so = 3'd3; alu = 4'd4; end
        6'h23:        begin so = 3'd1; ld = 1; rf = 1; men = 1; end
        6'h21:        begin so = 3'd1; ld = 1; rf = 1; men = 1; size = 2'd1; se = 1; end
        6'h25:        begin so = 3'd1; ld = 1; rf = 1; men = 1; size = 2'd1; end
        6'h20:        begin so = 3'd1; ld = 1; rf = 1; men = 1; size = 2'd2; se = 1; end
        6'h24:        begin so = 3'd1; ld = 1; rf = 1; men = 1; size = 2'd2; end
        6'h2B:        begin so = 3'd1; rw = 1; men = 1; end
        6'h29:        begin so = 3'd1; rw = 1; men = 1; size = 2'd1; end
        6'h28:        begin so = 3'd1; rw = 1; men = 1; size = 2'd2; end
        6'h04, 6'h05, 6'h06, 6'h07: begin br = 1; alu = 4'd1; end
        6'h02:        ta = 1;
        6'h03:        begin ta = 1; rf = 1; dest = 5'd31; end
        default:      unk = 1;
      endcase
      if (rf && !ta) dest = w[20:16];
    end
    e.ctrl  = {so, alu, ld, rf, br, ta, size, rw, se, hi, lo, men};
    e.dest  = dest;
    e.valid = 1'b1;
    e.unk   = unk;
    return e;
  endfunction

  function automatic bit ref_stall(input logic [31:0] w, input bit v, input ent_t ex, input bit haz);
    logic [5:0] op = w[31:26];
    bit use_rt = (op == 6'h00) || (op == 6'h28) || (op == 6'h29) || (op == 6'h2B) ||
                 (op == 6'h04) || (op == 6'h05);
    bool_hit: begin end
    return haz && v && ex.valid && ex.ctrl[10] && (ex.dest != 5'd0) &&
           ((ex.dest == w[25:21]) || (use_rt && (ex.dest == w[20:16])));
  endfunction

  function automatic ent_t bubble();
    ent_t e;
    e.ctrl = '0; e.dest = '0; e.valid = 1'b0; e.unk = 1'b0;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      ma[i] = bubble();
      mb[i] = bubble();
    end
    cnt_a = 0;
    cnt_b = 0;
  endtask

  task automatic drive(input logic [31:0] ins, input bit v, input bit st, input bit fl);
    cur_ins = ins; cur_v = v; cur_st = st; cur_fl = fl;
    if_a.instr_in = ins; if_a.instr_valid = v; if_a.stall_in = st; if_a.flush_in = fl;
    if_b.instr_in = ins; if_b.instr_valid = v; if_b.stall_in = st; if_b.flush_in = fl;
  endtask

  task automatic compare_all();
    check("a.ex_ctrl",   32'(if_a.ex_ctrl),    32'(ma[0].ctrl));
    check("a.ex_dest",   32'(if_a.ex_dest),    32'(ma[0].dest));
    check("a.ex_valid",  32'(if_a.ex_valid),   32'(ma[0].valid));
    check("a.ex_unk",    32'(if_a.ex_unknown), 32'(ma[0].unk));
    check("a.mem_ctrl",  32'(if_a.mem_ctrl),   32'(ma[1].ctrl));
    check("a.mem_dest",  32'(if_a.mem_dest),   32'(ma[1].dest));
    check("a.mem_valid", 32'(if_a.mem_valid),  32'(ma[1].valid));
    check("a.wb_ctrl",   32'(if_a.wb_ctrl),    32'(ma[2].ctrl));
    check("a.wb_dest",   32'(if_a.wb_dest),    32'(ma[2].dest));
    check("a.wb_valid",  32'(if_a.wb_valid),   32'(ma[2].valid));
    check("a.count",     32'(if_a.instr_count), cnt_a % 32'd65536);
    check("a.id_stall",  32'(if_a.id_stall),   32'(ref_stall(cur_ins, cur_v, ma[0], 1'b1)));
    check("b.ex_ctrl",   32'(if_b.ex_ctrl),    32'(mb[0].ctrl));
    check("b.ex_dest",   32'(if_b.ex_dest),    32'(mb[0].dest));
    check("b.ex_valid",  32'(if_b.ex_valid),   32'(mb[0].valid));
    check("b.ex_unk",    32'(if_b.ex_unknown), 32'(mb[0].unk));
    check("b.mem_ctrl",  32'(if_b.mem_ctrl),   32'(mb[1].ctrl));
    check("b.mem_valid", 32'(if_b.mem_valid),  32'(mb[1].valid));
    check("b.wb_ctrl",   32'(if_b.wb_ctrl),    32'(mb[2].ctrl));
    check("b.wb_dest",   32'(if_b.wb_dest),    32'(mb[2].dest));
    check("b.count",     32'(if_b.instr_count), cnt_b % 32'd4);
    check("b.id_stall",  32'(if_b.id_stall),   32'd0);
  endtask

  // One clock: drive inputs, check the combinational stall, advance the model with the edge.
  task automatic cycle(input logic [31:0] ins, input bit v, input bit st, input bit fl);
    bit sa;
    drive(ins, v, st, fl);
    #1;
    sa = ref_stall(ins, v, ma[0], 1'b1);
    obs_stall_a = if_a.id_stall;
    obs_stall_b = if_b.id_stall;
    check("a.id_stall_pre", 32'(obs_stall_a), 32'(sa));
    check("b.id_stall_pre", 32'(obs_stall_b), 32'd0);
    last_stall_a = sa;
    @(posedge clk);
    if (!st) begin
      ma[2] = ma[1]; ma[1] = ma[0];
      mb[2] = mb[1]; mb[1] = mb[0];
      if (fl || sa || !v) ma[0] = bubble();
      else begin ma[0] = ref_decode(ins); cnt_a++; end
      if (fl || !v) mb[0] = bubble();
      else begin mb[0] = ref_decode(ins); cnt_b++; end
    end
    #1;
    compare_all();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] rfn[9] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h11, 6'h13, 6'h08};
    logic [5:0] iop[5] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0F};
    logic [5:0] lop[5] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    logic [5:0] sop[3] = '{6'h28, 6'h29, 6'h2B};
    logic [4:0] rs = 5'($urandom_range(0, 3));
    logic [4:0] rt = 5'($urandom_range(0, 3));
    logic [4:0] rd = 5'($urandom_range(0, 3));
    logic [15:0] imm = 16'($urandom);
    case ($urandom_range(0, 11))
      0, 1:    return {6'h00, rs, rt, rd, 5'd0, rfn[$urandom_range(0, 8)]};
      2:       return {6'h00, rs, rt, rd, 5'd0, 6'h3F};
      3:       return 32'd0;
      4:       return {iop[$urandom_range(0, 4)], rs, rt, imm};
      5, 6, 7: return {lop[$urandom_range(0, 4)], rs, rt, imm};
      8:       return {sop[$urandom_range(0, 2)], rs, rt, imm};
      9:       return {6'($urandom_range(4, 7)), rs, rt, imm};
      10:      return {6'($urandom_range(2, 3)), 26'($urandom)};
      default: return {6'h3F, rs, rt, imm};
    endcase
  endfunction

  localparam logic [31:0] I_ADDU  = 32'h0022_1821; // ADDU $3,$1,$2
  localparam logic [31:0] I_LW    = 32'h8C22_0004; // LW   $2,4($1)
  localparam logic [31:0] I_ADDU2 = 32'h0045_2021; // ADDU $4,$2,$5
  localparam logic [31:0] I_SW    = 32'hAC22_0004; // SW   $2,4($1)
  localparam logic [31:0] I_UNK   = 32'hFC00_0000;

  initial begin
    logic [31:0] ins;
    bit v;
    reset = 1'b1;
    drive(32'd0, 1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    reset = 1'b0;

    cycle(I_ADDU, 1, 0, 0);
    check("dir.addu_ctrl",  32'(if_a.ex_ctrl),  32'h00200);
    check("dir.addu_dest",  32'(if_a.ex_dest),  32'd3);
    check("dir.addu_valid", 32'(if_a.ex_valid), 32'd1);
    cycle(32'd0, 0, 0, 0);
    cycle(32'd0, 0, 0, 0);
    check("dir.addu_wb",    32'(if_a.wb_ctrl),  32'h00200);
    check("dir.count1",     32'(if_a.instr_count), 32'd1);

    cycle(I_LW, 1, 0, 0);
    check("dir.lw_ctrl",    32'(if_a.ex_ctrl),  32'h08601);
    cycle(I_ADDU2, 1, 0, 0);
    check("dir.lu_stall_a", 32'(obs_stall_a),   32'd1);
    check("dir.lu_stall_b", 32'(obs_stall_b),   32'd0);
    check("dir.lu_bubble",  32'(if_a.ex_valid), 32'd0);
    check("dir.nohaz_b2b",  32'(if_b.ex_ctrl),  32'h00200);
    cycle(I_ADDU2, 1, 0, 0);
    check("dir.lu_release", 32'(obs_stall_a),   32'd0);
    check("dir.lu_addu",    32'(if_a.ex_ctrl),  32'h00200);
    check("dir.lu_dest",    32'(if_a.ex_dest),  32'd4);
    check("dir.lu_memgap",  32'(if_a.mem_valid), 32'd0);

    cycle(I_SW, 1, 0, 0);
    check("dir.sw_ctrl",    32'(if_a.ex_ctrl),  32'h08011);
    check("dir.sw_dest",    32'(if_a.ex_dest),  32'd0);
    cycle(I_UNK, 1, 0, 0);
    check("dir.unk_ctrl",   32'(if_a.ex_ctrl),  32'd0);
    check("dir.unk_flag",   32'(if_a.ex_unknown), 32'd1);
    check("dir.unk_valid",  32'(if_a.ex_valid), 32'd1);

    cycle(I_ADDU, 1, 0, 0);
    repeat (3) cycle(I_ADDU, 1, 1, 0);
    cycle(I_ADDU, 1, 0, 1);
    check("dir.flush",      32'(if_a.ex_valid), 32'd0);
    cycle(I_LW, 1, 0, 0);
    cycle(I_ADDU2, 1, 0, 1);
    cycle(I_LW, 1, 0, 0);
    cycle(I_ADDU2, 1, 1, 0);
    cycle(I_ADDU2, 1, 0, 0);
    cycle(I_ADDU2, 1, 0, 0);

    #2 reset = 1'b1;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    reset = 1'b0;
    repeat (5) cycle(I_ADDU, 1, 0, 0);
    check("dir.wrap_b",     32'(if_b.instr_count), 32'd1);
    check("dir.count_a5",   32'(if_a.instr_count), 32'd5);

    last_stall_a = 1'b0;
    ins = 32'd0;
    v = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!last_stall_a) begin
        ins = rand_instr();
        v = ($urandom_range(0, 9) != 0);
      end
      cycle(ins, v, $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ppu_control_pipe.md
Name: ppu_control_pipe

Overview:
Pipelined, parametrised successor to the PPU combinational decoder. Decodes the ID-stage instruction into the 18-bit PPU control word and carries it, with a destination register and a valid bit, through registered ID/EX, EX/MEM and MEM/WB stages. Adds load-use hazard detection with bubble insertion, global stall and flush handling, unknown-opcode flagging and a retired-decode counter. Sits between the IF/ID register and the datapath stage muxes.

Parameters:
CNT_W, 16, width of the decoded-instruction counter.
HAZARD_EN, 1, 1 enables load-use detection; 0 forces id_stall=0.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous, active-high reset.
instr_in  in  32  instruction in the ID stage.
instr_valid  in  1  instr_in holds a real instruction.
stall_in  in  1  global freeze; all stage registers hold.
flush_in  in  1  replace the ID/EX entry with a bubble.
id_stall  out  1  combinational load-use stall request to IF/ID and PC.
ex_ctrl, mem_ctrl, wb_ctrl  out  18  control words per stage.
ex_dest, mem_dest, wb_dest  out  5  destination register per stage.
ex_valid, mem_valid, wb_valid  out  1  stage holds a non-bubble.
ex_unknown  out  1  ID/EX entry decoded from an unsupported encoding.
instr_count  out  CNT_W  number of non-bubbles loaded into ID/EX.

Behaviour:
- Reset is asynchronous and active-high. All ctrl, dest, valid, ex_unknown and instr_count outputs go to 0. id_stall follows its equation, which evaluates to 0 because ex_valid=0.
- Control word fields are [17:15] SO, [14:11] ALU_OP, [10] Load, [9] RF_En, [8] B, [7] TA, [6:5] Size, [4] MEM_RW, [3] MEM_SE, [2] En_HI, [1] En_LO, [0] MEM_En.
- SO encoding: 000 rt, 001 sign-extended imm16, 010 zero-extended imm16, 011 imm16<<16.
- ALU_OP encoding: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 pass B.
- Size encoding: 00 word, 01 half, 10 byte. MEM_SE=1 means sign-extend the loaded data.
- Decode, R-type (op 000000):
  - ADD/ADDU: RF=1, ALU=0000.
  - SUB/SUBU: RF=1, ALU=0001.
  - AND: RF=1, ALU=0010.
  - OR: RF=1, ALU=0011.
  - MTHI: HI=1. MTLO: LO=1. JR: TA=1.
  - All-zero word (NOP): word 0, valid=1, not unknown.
- Decode, immediate ALU ops (RF=1):
  - ADDI/ADDIU: SO=001, ALU=0000.
  - ANDI: SO=010, ALU=0010.
  - ORI: SO=010, ALU=0011.
  - LUI: SO=011, ALU=0100.
- Decode, loads (SO=001, Load=1, RF=1, MEM_En=1):
  - LW: Size 00.
  - LH: Size 01, SE=1. LHU: Size 01.
  - LB: Size 10, SE=1. LBU: Size 10.
- Decode, stores (SO=001, MEM_RW=1, MEM_En=1): SW Size 00, SH Size 01, SB Size 10.
- Decode, branches and jumps:
  - BEQ/BNE/BGTZ/BLEZ: B=1, ALU=0001.
  - J: TA=1. JAL: TA=1, RF=1.
- Any other encoding: word 0, unknown=1.
- dest: rd for R-type with RF=1; rt for immediate ALU ops and loads; 31 for JAL; 0 otherwise.
- Clock edge with stall_in=1: every stage register and instr_count hold.
- Clock edge with stall_in=0:
  - MEM/WB <= EX/MEM, and EX/MEM <= ID/EX.
  - ID/EX <= bubble (ctrl 0, dest 0, valid 0, unknown 0) if flush_in | id_stall | ~instr_valid.
  - Otherwise ID/EX <= decode(instr_in) with valid=1.
  - Decode-to-ex_ctrl latency is 1 cycle; ex_ctrl to wb_ctrl adds 2 more.
- id_stall = HAZARD_EN & instr_valid & ex_valid & ex_ctrl[10] & (ex_dest!=0) & (ex_dest==rs | (uses_rt & ex_dest==rt)).
  - uses_rt is 1 for R-type, stores, BEQ and BNE.
  - A load-use pair yields exactly one bubble, as long as the IF/ID register holds instr_in while id_stall is high.
- Simultaneous events:
  - flush_in with id_stall: one bubble inserted, counter unchanged.
  - stall_in with flush_in or id_stall: stall_in dominates; nothing changes.
- instr_count increments by 1 when a valid=1 entry loads into ID/EX, and wraps modulo 2^CNT_W.
- Reset asserted mid-operation clears all stages immediately, without waiting for a clock edge.

Test Plan:
- Reset, then instr_valid=1 ADDU $3,$1,$2 (0x00221821) → next cycle ex_ctrl=18'h00200, ex_dest=3, ex_valid=1; two cycles later wb_ctrl=18'h00200; instr_count=1.
- LW $2,4($1) (0x8C220004) then ADDU $4,$2,$5 (0x00452021) → ex_ctrl=18'h08601; id_stall=1 for one cycle; ADDU reaches EX one cycle later; bubble visible in mem_valid=0.
- Repeat the previous scenario with HAZARD_EN=0 → id_stall stays 0 and ADDU follows LW back-to-back.
- SW $2,4($1) (0xAC220004) → ex_ctrl=18'h08011, ex_dest=0. Opcode 0x3F → ex_ctrl=0, ex_unknown=1, ex_valid=1.
- Stream of ADDUs with stall_in=1 for 3 cycles → all outputs and instr_count frozen. flush_in pulse → ex_valid=0 next cycle and count not incremented.
- CNT_W=2, 5 valid instructions → instr_count wraps to 1. Async reset pulse between clock edges → all outputs 0 immediately.
